// File: rtl/cnt_pkg.sv
// Shared types and constants for the four_bit_counter block.
package cnt_pkg;

    localparam int CNT_W = 4;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_MAX = 4'hF;
    localparam cnt_t CNT_MIN = 4'h0;

    typedef enum logic {
        DN = 1'b0,
        UP = 1'b1
    } dir_e;

endpackage

// File: rtl/cnt_next_calc.sv
// Combinational next-count and wrap-detect logic for four_bit_counter.
module cnt_next_calc
    import cnt_pkg::*;
#(
    parameter int WIDTH    = CNT_W,
    parameter bit SATURATE = 1'b0
) (
    input  logic [WIDTH-1:0] q,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q_d,
    output logic             wrap_d
);

    localparam logic [WIDTH-1:0] MAX_V = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_V = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    dir_e dir;
    assign dir = dir_e'(up_dn);

    // Priority clr > load > count > hold; only a true rollover raises wrap.
    always_comb begin
        q_d    = q;
        wrap_d = 1'b0;
        if (clr) begin
            q_d = MIN_V;
        end else if (load) begin
            q_d = load_val;
        end else if (en) begin
            if (dir == UP) begin
                if (q == MAX_V) begin
                    if (!SATURATE) begin
                        q_d    = MIN_V;
                        wrap_d = 1'b1;
                    end
                end else begin
                    q_d = q + ONE;
                end
            end else begin
                if (q == MIN_V) begin
                    if (!SATURATE) begin
                        q_d    = MAX_V;
                        wrap_d = 1'b1;
                    end
                end else begin
                    q_d = q - ONE;
                end
            end
        end
    end

endmodule

// File: rtl/four_bit_counter.sv
// Up/down counter with clear, load, optional saturation, terminal-count and wrap flags.
// Default integration ties en=1, up_dn=1, clr=0, load=0, load_val=0 for a free-running up-counter.
module four_bit_counter
    import cnt_pkg::*;
#(
    parameter int               WIDTH       = CNT_W,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter bit               SATURATE    = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             wrap_q;
    logic             wrap_d;

    cnt_next_calc #(
        .WIDTH    (WIDTH),
        .SATURATE (SATURATE)
    ) u_next (
        .q        (q_q),
        .en       (en),
        .up_dn    (up_dn),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .q_d      (q_d),
        .wrap_d   (wrap_d)
    );

    // rst is active-low despite its name.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q    <= RESET_VALUE;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    assign q    = q_q;
    assign wrap = wrap_q;
    assign tc   = (dir_e'(up_dn) == UP) ? (q_q == {WIDTH{1'b1}}) : (q_q == {WIDTH{1'b0}});

endmodule

// File: tb/tb_four_bit_counter.sv
// Directed self-checking bench for four_bit_counter (wrapping and saturating instances).
module tb_four_bit_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, up_dn, clr, load;
    logic [3:0] load_val;
    logic [3:0] q;
    logic       tc, wrap;

    logic       s_en, s_up_dn, s_clr, s_load;
    logic [3:0] s_load_val;
    logic [3:0] s_q;
    logic       s_tc, s_wrap;

    int checks   = 0;
    int failures = 0;

    logic [3:0] exp_q;
    logic       exp_wrap;

    always #5 clk = ~clk;

    four_bit_counter #(.WIDTH(4), .RESET_VALUE(4'h0), .SATURATE(1'b0)) u_dut (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .q(q), .tc(tc), .wrap(wrap)
    );

    four_bit_counter #(.WIDTH(4), .RESET_VALUE(4'h0), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .en(s_en), .up_dn(s_up_dn), .clr(s_clr), .load(s_load),
        .load_val(s_load_val), .q(s_q), .tc(s_tc), .wrap(s_wrap)
    );

    task automatic chk(input string tag, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; en = 1'b1; up_dn = 1'b1; clr = 1'b0; load = 1'b0; load_val = 4'h0;
        s_en = 1'b0; s_up_dn = 1'b1; s_clr = 1'b0; s_load = 1'b0; s_load_val = 4'h0;

        #6;
        chk("reset_q", q, 4'h0);
        chk("reset_wrap", 4'(wrap), 4'h0);
        #4 rst = 1'b1;

        // Free run: 16 edges, single wrap when q returns to 0.
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk($sformatf("run_q%0d", i), q, 4'(i % 16));
            chk($sformatf("run_wrap%0d", i), 4'(wrap), 4'(i == 16));
            if (i == 15) chk("run_tc_at_F", 4'(tc), 4'h1);
        end
        tick();
        chk("wrap_one_cycle", 4'(wrap), 4'h0);
        repeat (3) tick();
        chk("q_after_20", q, 4'h4);

        // Asynchronous reset between edges.
        #2 rst = 1'b0;
        #1 chk("async_rst_q", q, 4'h0);
        #2 rst = 1'b1;
        tick();
        chk("release_first", q, 4'h1);
        repeat (4) tick();
        chk("release_plus5", q, 4'h5);

        // Load / clear priority / hold.
        load_val = 4'hA; load = 1'b1;
        tick();
        chk("load_A", q, 4'hA);
        clr = 1'b1;
        tick();
        chk("clr_over_load", q, 4'h0);
        clr = 1'b0; load_val = 4'h7;
        tick();
        chk("load_7", q, 4'h7);
        load = 1'b0; en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("hold%0d", i), q, 4'h7);
        end

        // Down count through zero.
        load_val = 4'h2; load = 1'b1; en = 1'b1;
        tick();
        chk("load_2", q, 4'h2);
        load = 1'b0; up_dn = 1'b0;
        tick();
        chk("dn_1", q, 4'h1);
        chk("dn_tc_1", 4'(tc), 4'h0);
        tick();
        chk("dn_0", q, 4'h0);
        chk("dn_tc_0", 4'(tc), 4'h1);
        chk("dn_wrap_0", 4'(wrap), 4'h0);
        tick();
        chk("dn_F", q, 4'hF);
        chk("dn_wrap_F", 4'(wrap), 4'h1);
        chk("dn_tc_F", 4'(tc), 4'h0);
        tick();
        chk("dn_E", q, 4'hE);
        chk("dn_wrap_E", 4'(wrap), 4'h0);
        up_dn = 1'b1;
        tick();
        chk("dir_change_F", q, 4'hF);
        chk("dir_change_tc", 4'(tc), 4'h1);

        // Long up then down runs against a small model.
        exp_q = 4'hF;
        for (int i = 0; i < 32; i++) begin
            exp_wrap = (exp_q == 4'hF);
            exp_q    = exp_q + 4'd1;
            tick();
            chk("tog_up_q", q, exp_q);
            chk("tog_up_wrap", 4'(wrap), 4'(exp_wrap));
            chk("tog_up_tc", 4'(tc), 4'(exp_q == 4'hF));
        end
        up_dn = 1'b0;
        for (int i = 0; i < 32; i++) begin
            exp_wrap = (exp_q == 4'h0);
            exp_q    = exp_q - 4'd1;
            tick();
            chk("tog_dn_q", q, exp_q);
            chk("tog_dn_wrap", 4'(wrap), 4'(exp_wrap));
            chk("tog_dn_tc", 4'(tc), 4'(exp_q == 4'h0));
        end

        // Saturating instance.
        s_load_val = 4'hF; s_load = 1'b1;
        tick();
        chk("sat_load_F", s_q, 4'hF);
        s_load = 1'b0; s_en = 1'b1; s_up_dn = 1'b1;
        tick();
        chk("sat_hold_F", s_q, 4'hF);
        chk("sat_wrap_up", 4'(s_wrap), 4'h0);
        chk("sat_tc_up", 4'(s_tc), 4'h1);
        tick();
        chk("sat_hold_F2", s_q, 4'hF);
        s_clr = 1'b1;
        tick();
        chk("sat_clr", s_q, 4'h0);
        s_clr = 1'b0; s_up_dn = 1'b0;
        tick();
        chk("sat_hold_0", s_q, 4'h0);
        chk("sat_wrap_dn", 4'(s_wrap), 4'h0);
        chk("sat_tc_dn", 4'(s_tc), 4'h1);
        s_up_dn = 1'b1;
        tick();
        chk("sat_up_1", s_q, 4'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/four_bit_counter.md
Name: four_bit_counter

Overview:
- Synchronous 4-bit binary counter with asynchronous active-low reset.
- Adds count enable, up/down direction, synchronous clear, parallel load, optional saturation, and terminal-count and wrap status flags.
- Used as a general-purpose event/cycle counter and as a toggle-coverage target.
- Default integration uses only clk, rst and q; it then behaves as a free-running up-counter.

Parameters:
- WIDTH, 4, counter width in bits. The block is specified and verified at 4.
- RESET_VALUE, 4'h0, value loaded into q on reset.
- SATURATE, 0, 0 = wrap at the limits, 1 = hold at the limits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-low: 0 = in reset, 1 = run
- en  input  1  count enable; default port value 1'b1
- up_dn  input  1  1 = count up, 0 = count down; default 1'b1
- clr  input  1  synchronous clear to 0; default 1'b0
- load  input  1  synchronous parallel load; default 1'b0
- load_val  input  WIDTH  value captured by load; default '0
- q  output  WIDTH  registered count
- tc  output  1  combinational terminal count: q==4'hF when up_dn=1, q==4'h0 when up_dn=0
- wrap  output  1  registered one-cycle pulse, set on the edge where q wraps

Behaviour:
- Reset
  - rst=0 forces q=RESET_VALUE and wrap=0 immediately, with no clock needed.
  - Reset dominates all other inputs.
  - Release is synchronous-safe: the first count occurs on the first rising edge where rst=1.
- Priority on each rising edge with rst=1: clr > load > en count > hold.
  - clr=1: q<=0, wrap<=0.
  - else load=1: q<=load_val, wrap<=0.
  - else en=1, up_dn=1: q<=q+1. At 4'hF, q<=4'h0 and wrap<=1 when SATURATE=0; q stays 4'hF and wrap<=0 when SATURATE=1.
  - else en=1, up_dn=0: q<=q-1. At 4'h0, q<=4'hF and wrap<=1 when SATURATE=0; q stays 4'h0 when SATURATE=1.
  - else: q holds, wrap<=0.
- Latency: q reflects a count, load or clear one cycle after the sampling edge.
- wrap: high for exactly one cycle following each wrap event.
- tc: pure function of q and up_dn; no latency.
- Arithmetic: modulo 2^WIDTH, unsigned, with no X propagation from the carry.
- Reset mid-count: q returns to RESET_VALUE asynchronously, and counting resumes from RESET_VALUE after release.
- Direction change: takes effect on the next enabled edge. There is no extra hold cycle.
- All outputs are driven from flops except tc. There are no latches.

Decomposition:
- Shared package cnt_pkg:
  - typedef cnt_t (logic [WIDTH-1:0])
  - constants CNT_MAX=4'hF and CNT_MIN=4'h0
  - enum dir_e {DN=0, UP=1}
- Optional sub-module cnt_next_calc: combinational next-value and wrap-detect logic taking q, en, up_dn, clr, load, load_val and SATURATE. The top level holds only the flops and tc.

Test Plan:
- Reset and free run: rst=0 for 10 time units then 1, other inputs default → q=0 during reset; q counts 1,2,…,F,0 over 16 edges; wrap pulses once when q becomes 0.
- Reset mid-count: after 20 enabled edges (q=4), drive rst=0 between edges → q=0 before the next clock edge; after release, q=1 on the first edge, and 5 edges later q=5.
- Load/clear priority: load_val=4'hA with load=1 → q=A next cycle; clr=1 and load=1 together → q=0; en=0 → q holds across 3 edges.
- Down count and tc: load 4'h2, up_dn=0 → q=1, then 0 with tc=1, then F with wrap=1.
- Saturation: SATURATE=1, load F, up count → q stays F with wrap=0; down from 0 → q stays 0.
- Toggle coverage: run ≥32 edges up and down → every bit of q, tc and wrap toggles 0→1→0.
